// File: rtl/sdram_sample_reader.sv
// Avalon-MM pipelined read master that streams a block of SDRAM samples
// into a show-ahead FIFO feeding a valid/ready sample sink.
module sdram_sample_reader #(
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] num_samples,
    output logic        busy,
    output logic        irq,
    input  logic        irq_ack,
    output logic [31:0] words_out,
    output logic [23:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int UW = AW + 1;
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [UW:0]   DEPTH_L = (UW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] MAXP_L  = PW'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nx;
    logic [23:0]   addr_q;
    logic [31:0]   count_q;
    logic [31:0]   issued_q;
    logic [PW-1:0] pending_q;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [UW-1:0] used_q;
    logic [UW:0]   committed;
    logic          req, accept, push, pop, fifo_nonempty;
    logic          unused_bits;

    assign unused_bits = ^{base_addr[31:24], base_addr[1:0]};

    // Words already in the FIFO plus words still in flight must fit.
    assign committed = {1'b0, used_q} + (UW + 1)'(pending_q);
    assign fifo_nonempty = (used_q != '0);

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        accept   = 1'b0;
        push     = 1'b0;
        pop      = fifo_nonempty && sample_ready;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (num_samples == 32'd0) ? DONE : RUN;
            end
            RUN: begin
                req    = (issued_q != count_q) && (pending_q < MAXP_L)
                         && (committed < DEPTH_L);
                accept = req && !avm_waitrequest;
                push   = avm_readdatavalid;
                if (accept && (issued_q + 32'd1 == count_q))
                    state_nx = DRAIN;
            end
            DRAIN: begin
                push = avm_readdatavalid;
                if (pending_q == '0 && !fifo_nonempty)
                    state_nx = DONE;
            end
            DONE: begin
                if (irq_ack)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            issued_q  <= '0;
            pending_q <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used_q    <= '0;
            words_out <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                addr_q    <= {base_addr[23:2], 2'b00};
                count_q   <= num_samples;
                issued_q  <= '0;
                words_out <= '0;
            end
            if (accept) begin
                addr_q   <= addr_q + 24'd4;
                issued_q <= issued_q + 32'd1;
            end
            if (accept && !push)
                pending_q <= pending_q + PW'(1);
            else if (push && !accept)
                pending_q <= pending_q - PW'(1);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                words_out <= words_out + 32'd1;
            end
            if (push && !pop)
                used_q <= used_q + UW'(1);
            else if (pop && !push)
                used_q <= used_q - UW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= avm_readdata;
    end

    assign busy         = (state == RUN) || (state == DRAIN);
    assign irq          = (state == DONE);
    assign avm_read     = req;
    assign avm_address  = addr_q;
    assign sample_valid = fifo_nonempty;
    assign sample_data  = fifo_nonempty ? fifo_mem[rd_ptr] : 32'd0;
endmodule

// File: tb/tb_sdram_sample_reader.sv
// Randomized bench for sdram_sample_reader: Avalon slave model with
// in-order variable latency, random stalls and a random-ready sink.
module tb_sdram_sample_reader;
    localparam int FIFO_DEPTH  = 16;
    localparam int MAX_PENDING = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] num_samples = '0;
    logic        busy, irq;
    logic        irq_ack = 1'b0;
    logic [31:0] words_out;
    logic [23:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        int          due;
    } resp_t;

    resp_t       rq[$];
    logic [23:0] acc_addr[$];
    logic [23:0] stall_addr[$];
    logic [31:0] pop_data[$];
    int cyc = 0, acc_n = 0, resp_n = 0, pop_n = 0;
    int hold_err = 0, wtick = 0, max_out = 0, max_occ = 0, lat_max = 1;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_addr = '0;

    sdram_sample_reader #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_addr        (base_addr),
        .num_samples      (num_samples),
        .busy             (busy),
        .irq              (irq),
        .irq_ack          (irq_ack),
        .words_out        (words_out),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .sample_data      (sample_data),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [23:0] a);
        return {a, 8'h5A} ^ 32'h3C96_A50F;
    endfunction

    function automatic logic [23:0] exp_addr(input logic [31:0] b, input int i);
        logic [31:0] t;
        t = {b[31:2], 2'b00} + 32'(i) * 32'd4;
        return t[23:0];
    endfunction

    // One clock: drive slave/sink, observe the coming edge, advance.
    task automatic step(input int wmode, input int ready_pct, input bit hold_resp);
        bit    w;
        resp_t r;
        int    due;
        w = 1'b0;
        if (wmode == 1) w = ($urandom_range(0, 2) == 0);
        else if (wmode == 2) w = 1'b1;
        else if (wmode == 3) w = (acc_n == 1 && wtick < 3);
        avm_waitrequest   = w;
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
        if (!hold_resp && rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = r.d;
            resp_n++;
        end
        sample_ready = ($urandom_range(0, 99) < ready_pct);
        #1;
        if (prev_stall && (!avm_read || avm_address != prev_addr)) hold_err++;
        prev_stall = avm_read && w;
        prev_addr  = avm_address;
        if (avm_read && w) begin
            wtick++;
            stall_addr.push_back(avm_address);
        end
        if (avm_read && !w) begin
            acc_addr.push_back(avm_address);
            acc_n++;
            due = cyc + int'($urandom_range(1, lat_max));
            if (rq.size() > 0 && due <= rq[$].due) due = rq[$].due + 1;
            r.d   = mem_data(avm_address);
            r.due = due;
            rq.push_back(r);
        end
        if (sample_valid && sample_ready) begin
            pop_data.push_back(sample_data);
            pop_n++;
        end
        if (acc_n - resp_n > max_out) max_out = acc_n - resp_n;
        if (resp_n - pop_n > max_occ) max_occ = resp_n - pop_n;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, irq, avm_read, sample_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {busy, irq, avm_read, sample_valid});
        end
        checks++;
        if (words_out !== 32'd0 || avm_address !== 24'd0 || sample_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_values: words=%h addr=%h data=%h expected 0",
                     words_out, avm_address, sample_data);
        end
        reset = 1'b0;
        step(0, 0, 0);
    endtask

    task automatic test_transfer(input logic [31:0] base, input int n, input int wmode,
                                 input int ready_pct, input int lmax, input int stall,
                                 input bit poke);
        int k, bad, exp16;
        acc_n = 0; resp_n = 0; pop_n = 0; hold_err = 0; wtick = 0;
        max_out = 0; max_occ = 0; lat_max = lmax; prev_stall = 1'b0;
        acc_addr.delete(); pop_data.delete(); stall_addr.delete();
        start = 1'b1; base_addr = base; num_samples = 32'(n);
        step(wmode, (stall > 0) ? 0 : ready_pct, 0);
        start = 1'b0; base_addr = $urandom; num_samples = $urandom;
        checks++;
        if (n == 0) begin
            if (irq !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL zero_done: irq=%b busy=%b expected irq=1 busy=0", irq, busy);
            end
        end else if (busy !== 1'b1 || avm_read !== 1'b1) begin
            failures++;
            $display("FAIL first_read: busy=%b avm_read=%b expected 1 1", busy, avm_read);
        end
        k = 0;
        while (irq !== 1'b1 && k < 4000) begin
            if (poke && k == 3) begin
                start = 1'b1; base_addr = 32'h0000_DE00; num_samples = 32'd5;
                irq_ack = 1'b1;
            end
            step(wmode, (k < stall) ? 0 : ready_pct, 0);
            start = 1'b0; irq_ack = 1'b0;
            if (poke && k == 3) begin
                checks++;
                if (busy !== 1'b1 || irq !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_start_ack: busy=%b irq=%b expected 1 0", busy, irq);
                end
            end
            if (stall > 0 && k == stall - 1) begin
                exp16 = (n < FIFO_DEPTH) ? n : FIFO_DEPTH;
                checks++;
                if (acc_n != exp16 || avm_read !== 1'b0 || sample_valid !== 1'b1
                    || max_occ != exp16) begin
                    failures++;
                    $display("FAIL backpressure: acc=%0d read=%b valid=%b occ=%0d expected %0d 0 1 %0d",
                             acc_n, avm_read, sample_valid, max_occ, exp16, exp16);
                end
            end
            k++;
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL timeout: irq=%b expected 1 within budget", irq);
        end
        bad = 0;
        foreach (acc_addr[i]) if (acc_addr[i] !== exp_addr(base, i)) bad++;
        checks++;
        if (acc_n != n || bad != 0) begin
            failures++;
            $display("FAIL addr_seq: reads=%0d bad=%0d expected reads=%0d bad=0", acc_n, bad, n);
        end
        bad = 0;
        foreach (pop_data[i]) if (pop_data[i] !== mem_data(exp_addr(base, i))) bad++;
        checks++;
        if (pop_data.size() != n || bad != 0) begin
            failures++;
            $display("FAIL data_seq: words=%0d bad=%0d expected words=%0d bad=0",
                     pop_data.size(), bad, n);
        end
        checks++;
        if (words_out !== 32'(n)) begin
            failures++;
            $display("FAIL words_out: got %0d expected %0d", words_out, n);
        end
        checks++;
        if (hold_err != 0 || max_out > MAX_PENDING || max_occ > FIFO_DEPTH) begin
            failures++;
            $display("FAIL limits: hold_err=%0d pending=%0d occ=%0d expected 0 <=%0d <=%0d",
                     hold_err, max_out, max_occ, MAX_PENDING, FIFO_DEPTH);
        end
        if (wmode == 3) begin
            bad = 0;
            foreach (stall_addr[i]) if (stall_addr[i] !== exp_addr(base, 1)) bad++;
            checks++;
            if (stall_addr.size() != 3 || bad != 0) begin
                failures++;
                $display("FAIL wait_hold: stalls=%0d bad=%0d expected 3 0",
                         stall_addr.size(), bad);
            end
        end
        irq_ack = 1'b1;
        step(0, 100, 0);
        irq_ack = 1'b0;
        checks++;
        if (irq !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL irq_ack: irq=%b busy=%b expected 0 0", irq, busy);
        end
    endtask

    task automatic test_reset_midrun();
        int k, seen;
        acc_n = 0; resp_n = 0; pop_n = 0; lat_max = 1;
        acc_addr.delete(); pop_data.delete();
        start = 1'b1; base_addr = 32'h100; num_samples = 32'd8;
        step(0, 0, 1);
        start = 1'b0;
        k = 0;
        while (acc_n < 3 && k < 20) begin
            step(0, 0, 1);
            k++;
        end
        checks++;
        if (acc_n != 3) begin
            failures++;
            $display("FAIL midrun_setup: reads=%0d expected 3", acc_n);
        end
        reset = 1'b1;
        step(2, 0, 1);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || avm_read !== 1'b0 || avm_address !== 24'd0) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b read=%b addr=%h expected 0 0 0",
                     busy, avm_read, avm_address);
        end
        seen = 0;
        repeat (8) begin
            step(0, 100, 0);
            if (sample_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || pop_data.size() != 0 || words_out !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stale_discard: valid_cycles=%0d pops=%0d words=%0d busy=%b expected 0 0 0 0",
                     seen, pop_data.size(), words_out, busy);
        end
        test_transfer(32'h200, 2, 0, 100, 2, 0, 0);
    endtask

    initial begin
        test_reset();
        test_transfer(32'h100, 4, 0, 100, 1, 0, 0);
        test_transfer(32'h1000, 40, 0, 100, 4, 60, 0);
        test_transfer(32'h100, 6, 3, 100, 2, 0, 0);
        test_transfer(32'h40, 0, 0, 100, 1, 0, 0);
        test_transfer(32'h300, 20, 0, 40, 3, 0, 1);
        test_reset_midrun();
        test_transfer(32'hABFF_FFF6, 6, 1, 70, 3, 0, 0);
        for (int i = 0; i < 5; i++)
            test_transfer($urandom, int'($urandom_range(1, 48)), 1,
                          int'($urandom_range(25, 100)), int'($urandom_range(1, 6)), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
